// File: rtl/crossbar_slave_mem_pkg.sv
// Shared constants and the state type for the crossbar memory slave.
// Imported by the interface, the RAM and the slave FSM.
package crossbar_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } slave_mem_state_t;

endpackage

// File: rtl/crossbar_slave_mem_if.sv
// Crossbar-to-slave request/response bundle.
// The crossbar drives through the master modport and the memory slave uses the slave modport.
interface crossbar_slave_mem_if;

    logic                           req;
    logic [crossbar_pkg::ADDR_W-1:0] addr;
    logic [crossbar_pkg::DATA_W-1:0] wdata;
    logic                           cmd;
    logic                           ack;
    logic [crossbar_pkg::DATA_W-1:0] rdata;

    modport master (output req, addr, wdata, cmd, input ack, rdata);
    modport slave  (input req, addr, wdata, cmd, output ack, rdata);

endinterface

// File: rtl/crossbar_slave_mem_array.sv
// Single-port DEPTH x 32 synchronous RAM with a write enable and a registered read port.
// The read register clears on reset; the storage array itself is never reset.
module slave_mem_array
    import crossbar_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[idx] <= wdata;
        end
    end

    // A write access leaves the last read value on the output untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (en && !we) begin
            rdata_reg <= mem[idx];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/crossbar_slave_mem.sv
// Word-addressed memory slave with WAIT_STATES programmable wait cycles before a one-cycle ack.
// Optional read/write statistics counters are enabled by the macro CROSSBAR_SLAVE_MEM_STATS_EN.
module crossbar_slave_mem
    import crossbar_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    crossbar_slave_mem_if.slave  bus
`ifdef CROSSBAR_SLAVE_MEM_STATS_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    slave_mem_state_t  state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [AW-1:0]     idx_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              cmd_reg;
    logic              commit;
    logic              capture;
    logic [AW-1:0]     idx_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              cmd_sel;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{bus.addr[ADDR_W-1:AW+2], bus.addr[1:0]};

    assign capture = (state_reg == IDLE) && bus.req;

    // With zero wait states the access commits on the capture edge, so use the live bus.
    assign idx_sel   = (state_reg == IDLE) ? bus.addr[AW+1:2] : idx_reg;
    assign wdata_sel = (state_reg == IDLE) ? bus.wdata        : wdata_reg;
    assign cmd_sel   = (state_reg == IDLE) ? bus.cmd          : cmd_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    if (WAIT_STATES == 0) begin
                        state_next = ACK;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ACK;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            idx_reg   <= '0;
            wdata_reg <= '0;
            cmd_reg   <= CMD_READ;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                idx_reg   <= bus.addr[AW+1:2];
                wdata_reg <= bus.wdata;
                cmd_reg   <= bus.cmd;
            end
        end
    end

    slave_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (commit),
        .we    (cmd_sel == CMD_WRITE),
        .idx   (idx_sel),
        .wdata (wdata_sel),
        .rdata (bus.rdata)
    );

    assign bus.ack = (state_reg == ACK);

`ifdef CROSSBAR_SLAVE_MEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (commit) begin
            if (cmd_sel == CMD_WRITE) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule
